// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory sequencer.
// Holds the FSM state encoding, field positions and the HALT opcode test.
package imem_ctrl_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 18;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEN_W   = PTR_W + 1;
    localparam int OP_HI   = 17;
    localparam int OP_LO   = 14;

    localparam logic [3:0]       HALT_OP  = 4'hF;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[OP_HI:OP_LO] == HALT_OP);
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Load stream, instruction stream, branch redirect and memory bus of the sequencer.
// The master modport is the controller's view; slave is the surrounding logic.
interface imem_ctrl_if;
    import imem_ctrl_pkg::*;

    logic               ld_valid;
    logic               ld_ready;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic               branch_valid;
    logic [ADDR_W-1:0]  branch_addr;

    logic               mem_read;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        input  ld_valid, ld_data, ld_last,
        output ld_ready,
        output instr_valid, instr,
        input  instr_ready, branch_valid, branch_addr,
        output mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output ld_valid, ld_data, ld_last,
        input  ld_ready,
        input  instr_valid, instr,
        output instr_ready, branch_valid, branch_addr,
        input  mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: loads a program from a word stream, then fetches
// and presents instructions in order or by branch until HALT or PC leaves the program.
module imem_ctrl
    import imem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             load_start,
    input  logic             run,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] prog_len,
    imem_ctrl_if.master      bus
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [LEN_W-1:0]   prog_len_r;
    logic [LEN_W-1:0]   prog_len_nxt_s;
    logic [INSTR_W-1:0] instr_r;
    logic [INSTR_W-1:0] instr_nxt_s;
    logic               ld_acc_s;
    logic [ADDR_W-1:0]  target_s;
    logic [ADDR_W-1:0]  len_ext_s;

    logic               ld_ready_r;
    logic               mem_read_r;
    logic               instr_valid_r;
    logic               busy_r;
    logic               done_r;

    // PC only ever holds in-program addresses, so pc+1 cannot overflow.
    assign target_s  = bus.branch_valid ? bus.branch_addr : (pc_r + ADDR_W'(1'b1));
    assign len_ext_s = {{(ADDR_W - LEN_W){1'b0}}, prog_len_r};

    // Next-state and datapath-update logic for the sequencer FSM.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        prog_len_nxt_s = prog_len_r;
        instr_nxt_s    = instr_r;
        ld_acc_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt_s    = ST_LOAD;
                    wr_ptr_nxt_s   = {PTR_W{1'b0}};
                    prog_len_nxt_s = {LEN_W{1'b0}};
                end else if (run && (prog_len_r != {LEN_W{1'b0}})) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ld_acc_s = bus.ld_valid;
                if (bus.ld_valid) begin
                    wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
                    if (bus.ld_last || (wr_ptr_r == PTR_LAST)) begin
                        prog_len_nxt_s = {1'b0, wr_ptr_r} + LEN_W'(1'b1);
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_LATCH;
            end
            ST_LATCH: begin
                instr_nxt_s = bus.mem_rdata;
                state_nxt_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.instr_ready) begin
                    if (is_halt(instr_r)) begin
                        state_nxt_s = ST_DONE;
                    end else if (target_s >= len_ext_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        pc_nxt_s    = target_s;
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            pc_r       <= {ADDR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            prog_len_r <= {LEN_W{1'b0}};
            instr_r    <= {INSTR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            prog_len_r <= prog_len_nxt_s;
            instr_r    <= instr_nxt_s;
        end
    end

    // Status flags registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ld_ready_r    <= 1'b0;
            mem_read_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            ld_ready_r    <= (state_nxt_s == ST_LOAD);
            mem_read_r    <= (state_nxt_s == ST_FETCH);
            instr_valid_r <= (state_nxt_s == ST_PRESENT);
            busy_r        <= (state_nxt_s != ST_IDLE);
            done_r        <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign prog_len        = prog_len_r;
    assign bus.ld_ready    = ld_ready_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr       = instr_r;
    assign bus.mem_read    = mem_read_r;
    assign bus.mem_raddr   = pc_r;
    // Write strobe follows the accepted word directly; data is gated so the bus idles at zero.
    assign bus.mem_write   = ld_acc_s;
    assign bus.mem_waddr   = {{(ADDR_W - PTR_W){1'b0}}, wr_ptr_r};
    assign bus.mem_wdata   = ld_acc_s ? bus.ld_data : {INSTR_W{1'b0}};

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl: a program-level reference model predicts every
// memory strobe, presented instruction and done pulse; literal cases pin the model.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    localparam int NSTEP = 24;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             load_start = 1'b0;
    logic             run = 1'b0;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] prog_len;

    imem_ctrl_if bus_if();

    imem_ctrl dut (
        .clk        (clk),
        .nrst       (nrst),
        .load_start (load_start),
        .run        (run),
        .busy       (busy),
        .done       (done),
        .prog_len   (prog_len),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    // Memory stub: registered read, cleared by the shared reset.
    logic [INSTR_W-1:0] ram [DEPTH];
    logic [INSTR_W-1:0] rdata_q;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (bus_if.mem_write) ram[bus_if.mem_waddr[PTR_W-1:0]] <= bus_if.mem_wdata;
            rdata_q <= bus_if.mem_read ? ram[bus_if.mem_raddr[PTR_W-1:0]] : '0;
        end
    end
    assign bus_if.mem_rdata = rdata_q;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (program level) ----------------
    typedef enum int {M_IDLE, M_LOAD, M_RUN} mode_t;
    mode_t              mode = M_IDLE;
    int                 cnt = 0;
    int                 len = 0;
    logic [INSTR_W-1:0] mmem [DEPTH];
    bit                 br_v [NSTEP];
    int                 br_a [NSTEP];
    logic [INSTR_W-1:0] exp_instr_q[$];
    int                 exp_read_q[$];
    logic [INSTR_W-1:0] hs_log[$];
    int                 rd_log[$];
    int                 write_cnt = 0, read_cnt = 0, done_cnt = 0;
    bit                 read_due = 0, rd_d1 = 0, valid_due = 0, done_due = 0;
    bit                 cp_hs, cp_last, cp_start;

    task automatic model_reset();
        mode = M_IDLE; cnt = 0; len = 0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        exp_instr_q.delete(); exp_read_q.delete();
        read_due = 0; rd_d1 = 0; valid_due = 0; done_due = 0;
    endtask

    // Walk the program as the decoder would see it, using the branch plan.
    task automatic build_trace();
        int pc = 0;
        int nxt;
        logic [INSTR_W-1:0] w;
        exp_instr_q.delete(); exp_read_q.delete();
        for (int k = 0; k < NSTEP; k++) begin
            exp_read_q.push_back(pc);
            w = mmem[pc];
            exp_instr_q.push_back(w);
            if (w[17:14] == 4'hF) break;
            nxt = br_v[k] ? br_a[k] : pc + 1;
            if (nxt >= len) break;
            pc = nxt;
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (!nrst) begin
            model_reset();
        end else begin
            chk("strobe_excl", 32'(bus_if.mem_read & bus_if.mem_write), 32'd0);
            chk("busy", 32'(busy), 32'(mode != M_IDLE));
            chk("ld_ready", 32'(bus_if.ld_ready), 32'(mode == M_LOAD));
            chk("mem_write", 32'(bus_if.mem_write), 32'(mode == M_LOAD && bus_if.ld_valid));
            if (bus_if.mem_write) begin
                write_cnt++;
                chk("mem_waddr", 32'(bus_if.mem_waddr), 32'(cnt));
                chk("mem_wdata", 32'(bus_if.mem_wdata), 32'(bus_if.ld_data));
            end
            chk("mem_read", 32'(bus_if.mem_read), 32'(read_due));
            if (bus_if.mem_read) begin
                read_cnt++;
                rd_log.push_back(int'(bus_if.mem_raddr));
                if (exp_read_q.size() == 0) chk("read_extra", 32'd1, 32'd0);
                else chk("mem_raddr", 32'(bus_if.mem_raddr), 32'(exp_read_q.pop_front()));
            end
            chk("instr_valid", 32'(bus_if.instr_valid), 32'(valid_due));
            cp_hs = bus_if.instr_valid && bus_if.instr_ready;
            cp_last = 1'b0;
            if (bus_if.instr_valid) begin
                if (exp_instr_q.size() == 0) chk("instr_extra", 32'd1, 32'd0);
                else chk("instr", 32'(bus_if.instr), 32'(exp_instr_q[0]));
            end
            if (cp_hs && exp_instr_q.size() > 0) begin
                hs_log.push_back(bus_if.instr);
                void'(exp_instr_q.pop_front());
                cp_last = (exp_instr_q.size() == 0);
            end
            chk("done", 32'(done), 32'(done_due));
            if (done) done_cnt++;
            chk("prog_len", 32'(prog_len), 32'(len));

            cp_start = 1'b0;
            case (mode)
                M_IDLE: begin
                    if (load_start) begin
                        mode = M_LOAD; cnt = 0; len = 0;
                    end else if (run && len > 0) begin
                        mode = M_RUN; build_trace(); cp_start = 1'b1;
                    end
                end
                M_LOAD: begin
                    if (bus_if.ld_valid) begin
                        mmem[cnt] = bus_if.ld_data;
                        cnt++;
                        if (bus_if.ld_last || cnt == DEPTH) begin
                            len = cnt; mode = M_IDLE;
                        end
                    end
                end
                M_RUN: if (done_due) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
            valid_due = (valid_due && !bus_if.instr_ready) || rd_d1;
            rd_d1     = read_due;
            read_due  = cp_start || (cp_hs && !cp_last);
            done_due  = cp_hs && cp_last;
        end
    end

    // ---------------- stimulus ----------------
    logic [INSTR_W-1:0] stim_w [20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int n, input int last_idx, input bit gaps);
        int i = 0;
        int guard = 0;
        bit v, acc;
        load_start = 1'b1; tick(); load_start = 1'b0;
        while (i < n && guard < 4 * n + 8) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_if.ld_valid = v;
            bus_if.ld_data  = stim_w[i];
            bus_if.ld_last  = (i == last_idx);
            run        = bus_if.ld_ready && ($urandom_range(0, 7) == 0);
            load_start = bus_if.ld_ready && ($urandom_range(0, 7) == 0);
            acc = v && bus_if.ld_ready;
            tick(); guard++;
            if (acc) i++;
        end
        bus_if.ld_valid = 1'b0; bus_if.ld_last = 1'b0; run = 1'b0; load_start = 1'b0;
        bus_if.ld_data = 18'($urandom);
        tick();
    endtask

    task automatic plan_branches(input bit rnd, input int plen);
        for (int k = 0; k < NSTEP; k++) begin
            br_v[k] = rnd && ($urandom_range(0, 3) == 0);
            br_a[k] = ($urandom_range(0, 9) == 0) ? 65535 : $urandom_range(0, plen + 2);
        end
        if (rnd) begin
            br_v[NSTEP-1] = 1'b1;
            br_a[NSTEP-1] = 16 + $urandom_range(0, 100);
        end
    endtask

    // ready_mode: 0 random, 1 always ready, 2 stall five presented cycles first.
    task automatic run_prog(input int ready_mode, output int cyc);
        int k = 0;
        int stall = 0;
        bit seen = 0;
        bit rdy, hs_pre;
        cyc = 0;
        run = 1'b1; tick(); run = 1'b0;
        while (!seen && cyc < 400) begin
            case (ready_mode)
                0:       rdy = ($urandom_range(0, 3) != 0);
                1:       rdy = 1'b1;
                default: rdy = (stall >= 5);
            endcase
            if (bus_if.instr_valid && !rdy) stall++;
            bus_if.instr_ready = rdy;
            if (bus_if.instr_valid) begin
                bus_if.branch_valid = br_v[k];
                bus_if.branch_addr  = 16'(br_a[k]);
            end else begin
                bus_if.branch_valid = 1'($urandom);
                bus_if.branch_addr  = 16'($urandom);
            end
            load_start = ($urandom_range(0, 5) == 0);
            run        = ($urandom_range(0, 5) == 0);
            hs_pre = bus_if.instr_valid && rdy;
            tick(); cyc++;
            if (hs_pre && k < NSTEP - 1) k++;
            seen = done;
        end
        bus_if.instr_ready = 1'b0; bus_if.branch_valid = 1'b0;
        load_start = 1'b0; run = 1'b0;
        chk("run_completes", 32'(seen), 32'd1);
        tick();
    endtask

    function automatic logic [INSTR_W-1:0] rand_word(input bit halt);
        logic [INSTR_W-1:0] w = 18'($urandom);
        if (halt) w[17:14] = 4'hF;
        else if (w[17:14] == 4'hF) w[17:14] = 4'hE;
        return w;
    endfunction

    initial begin
        int cyc, wc0, rc0, dc0, n;
        bus_if.ld_valid = 1'b0; bus_if.ld_data = '0; bus_if.ld_last = 1'b0;
        bus_if.instr_ready = 1'b0; bus_if.branch_valid = 1'b0; bus_if.branch_addr = '0;

        // Reset: every output low even with junk on the load data.
        bus_if.ld_data = 18'h2A5A5;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_ld_ready", 32'(bus_if.ld_ready), 32'd0);
        chk("rst_instr_valid", 32'(bus_if.instr_valid), 32'd0);
        chk("rst_instr", 32'(bus_if.instr), 32'd0);
        chk("rst_strobes", 32'({bus_if.mem_read, bus_if.mem_write}), 32'd0);
        chk("rst_addrs", 32'(bus_if.mem_raddr | bus_if.mem_waddr), 32'd0);
        chk("rst_wdata", 32'(bus_if.mem_wdata), 32'd0);
        tick(); nrst = 1'b1; tick();

        // Run with an empty program is ignored.
        run = 1'b1; tick(); run = 1'b0;
        @(negedge clk);
        chk("run_empty_ignored", 32'(busy), 32'd0);

        // Three-word program ending in HALT, gapless.
        stim_w[0] = 18'h00001; stim_w[1] = 18'h00002; stim_w[2] = 18'h3C000;
        wc0 = write_cnt;
        load_prog(3, 2, 1'b0);
        @(negedge clk);
        chk("load3_writes", 32'(write_cnt - wc0), 32'd3);
        chk("load3_prog_len", 32'(prog_len), 32'd3);
        chk("load3_ld_ready", 32'(bus_if.ld_ready), 32'd0);

        plan_branches(1'b0, 3);
        dc0 = done_cnt;
        run_prog(1, cyc);
        chk("run3_latency", 32'(cyc), 32'd9);
        chk("run3_i0", 32'(hs_log[hs_log.size()-3]), 32'h00001);
        chk("run3_i1", 32'(hs_log[hs_log.size()-2]), 32'h00002);
        chk("run3_i2", 32'(hs_log[hs_log.size()-1]), 32'h3C000);
        chk("run3_done_once", 32'(done_cnt - dc0), 32'd1);
        @(negedge clk);
        chk("run3_idle", 32'(busy), 32'd0);

        // Decoder stalls five cycles on the first instruction; rerun same program.
        run_prog(2, cyc);
        chk("stall_latency", 32'(cyc), 32'd14);
        chk("stall_last", 32'(hs_log[hs_log.size()-1]), 32'h3C000);

        // Overlong load: only sixteen words are taken.
        for (int i = 0; i < 20; i++) stim_w[i] = rand_word(1'b0);
        wc0 = write_cnt;
        load_prog(20, -1, 1'b1);
        @(negedge clk);
        chk("load20_writes", 32'(write_cnt - wc0), 32'd16);
        chk("load20_prog_len", 32'(prog_len), 32'd16);

        // Branch back to 0, fall through, then branch out of the program.
        stim_w[0] = 18'h00010; stim_w[1] = 18'h04020; stim_w[2] = 18'h08030;
        load_prog(3, 2, 1'b0);
        plan_branches(1'b0, 3);
        br_v[0] = 1'b1; br_a[0] = 0;
        br_v[2] = 1'b1; br_a[2] = 9;
        rc0 = read_cnt; dc0 = done_cnt;
        run_prog(1, cyc);
        repeat (3) tick();
        chk("br_reads", 32'(read_cnt - rc0), 32'd3);
        chk("br_raddr0", 32'(rd_log[rd_log.size()-3]), 32'd0);
        chk("br_raddr1", 32'(rd_log[rd_log.size()-2]), 32'd0);
        chk("br_raddr2", 32'(rd_log[rd_log.size()-1]), 32'd1);
        chk("br_instr1", 32'(hs_log[hs_log.size()-2]), 32'h00010);
        chk("br_done_once", 32'(done_cnt - dc0), 32'd1);

        // Randomized programs, branches and decoder back-pressure.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < 20; i++) stim_w[i] = rand_word($urandom_range(0, 7) == 0);
            if (it % 4 == 3) load_prog(20, -1, 1'b1);
            else load_prog(n, n - 1, 1'b1);
            for (int r = 0; r < 3; r++) begin
                plan_branches(1'b1, int'(prog_len));
                run_prog(0, cyc);
            end
        end

        // Reset in the middle of execution drops the program.
        plan_branches(1'b0, int'(prog_len));
        run = 1'b1; tick(); run = 1'b0;
        bus_if.instr_ready = 1'b1;
        repeat (4) tick();
        nrst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_prog_len", 32'(prog_len), 32'd0);
        chk("midrst_read", 32'(bus_if.mem_read), 32'd0);
        tick(); nrst = 1'b1; bus_if.instr_ready = 1'b0; tick();
        run = 1'b1; tick(); run = 1'b0;
        @(negedge clk);
        chk("midrst_run_ignored", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
